// File: rtl/isqrt_pkg.sv
// Shared types and elaboration helpers for the sequential integer square root.
package isqrt_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAlign = 2'd1,
        StIter  = 2'd2,
        StDone  = 2'd3
    } isqrt_state_t;

    // Radicand width must be even so the result takes exactly IN_W/2 digit steps.
    function automatic bit in_w_valid(int unsigned w);
        return ((w % 2) == 0) && (w >= 4);
    endfunction

endpackage

// File: rtl/isqrt_step.sv
// One digit-by-digit iteration: trial-subtract r+d from the partial remainder x.
module isqrt_step
    import isqrt_pkg::*;
#(
    parameter int unsigned IN_W = 40
) (
    input  logic [IN_W-1:0] x_i,
    input  logic [IN_W-1:0] r_i,
    input  logic [IN_W-1:0] d_i,
    output logic [IN_W-1:0] x_o,
    output logic [IN_W-1:0] r_o,
    output logic [IN_W-1:0] d_o
);

    logic [IN_W:0] trial;

    always_comb begin
        // One extra bit so r+d cannot wrap before the compare.
        trial = {1'b0, r_i} + {1'b0, d_i};
        x_o   = x_i;
        r_o   = r_i >> 1;
        d_o   = d_i >> 2;
        if ({1'b0, x_i} >= trial) begin
            x_o = x_i - trial[IN_W-1:0];
            r_o = (r_i >> 1) + d_i;
        end
    end

endmodule

// File: rtl/isqrt_seq.sv
// Sequential integer square root, two radicand bits per cycle, fixed N+3 latency.
module isqrt_seq
    import isqrt_pkg::*;
#(
    parameter int unsigned IN_W  = 40,
    parameter bit          ROUND = 1'b0,
    localparam int unsigned N    = IN_W / 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [IN_W-1:0] a_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [N-1:0]    result_o,
    output logic [N:0]      rem_o,
    output logic            exact_o
);

    if (!in_w_valid(IN_W)) begin : g_bad_in_w
        $error("isqrt_seq: IN_W must be even and >= 4");
    end

    localparam logic [IN_W-1:0] DInit  = {2'b01, {(IN_W-2){1'b0}}};
    localparam logic [N-1:0]    ResOne = {{(N-1){1'b0}}, 1'b1};

    isqrt_state_t    state_q, state_d;
    logic [IN_W-1:0] x_q, x_d;
    logic [IN_W-1:0] r_q, r_d;
    logic [IN_W-1:0] d_q, d_d;
    logic [N-1:0]    result_q, result_d;
    logic [N:0]      rem_q, rem_d;
    logic            exact_q, exact_d;

    logic [IN_W-1:0] x_step, r_step, d_step;
    logic [N-1:0]    r_res;
    logic [N-1:0]    res_final;

    isqrt_step #(
        .IN_W (IN_W)
    ) u_step (
        .x_i (x_q),
        .r_i (r_q),
        .d_i (d_q),
        .x_o (x_step),
        .r_o (r_step),
        .d_o (d_step)
    );

    always_comb begin
        r_res     = r_q[N-1:0];
        res_final = r_res;
        // Round up when the remainder exceeds r, i.e. sqrt(a) > r + 1/2.
        if (ROUND && (x_q > r_q) && (r_res != '1)) begin
            res_final = r_res + ResOne;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        r_d      = r_q;
        d_d      = d_q;
        result_d = result_q;
        rem_d    = rem_q;
        exact_d  = exact_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start_i) begin
                    x_d     = a_i;
                    r_d     = '0;
                    d_d     = DInit;
                    state_d = StAlign;
                end
            end
            StAlign: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if ((d_q > x_q) && (d_q != '0)) begin
                    d_d = d_q >> 2;
                end else begin
                    state_d = StIter;
                end
            end
            StIter: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (d_q != '0) begin
                    x_d = x_step;
                    r_d = r_step;
                    d_d = d_step;
                end else begin
                    state_d  = StDone;
                    result_d = res_final;
                    rem_d    = x_q[N:0];
                    exact_d  = (x_q == '0);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            x_q      <= '0;
            r_q      <= '0;
            d_q      <= '0;
            result_q <= '0;
            rem_q    <= '0;
            exact_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            r_q      <= r_d;
            d_q      <= d_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            exact_q  <= exact_d;
        end
    end

    assign busy_o   = (state_q == StAlign) || (state_q == StIter);
    assign valid_o  = (state_q == StDone);
    assign result_o = result_q;
    assign rem_o    = rem_q;
    assign exact_o  = exact_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// Bench for isqrt_seq: 40-bit truncating and rounding instances plus a 16-bit sweep.
module tb_isqrt_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, abort;
    logic [39:0] a;
    logic        busy40, valid40, exact40;
    logic [19:0] res40;
    logic [20:0] rem40;
    logic        busy40r, valid40r, exact40r;
    logic [19:0] res40r;
    logic [20:0] rem40r;

    logic        start16, abort16;
    logic [15:0] a16;
    logic        busy16, valid16, exact16;
    logic [7:0]  res16;
    logic [8:0]  rem16;

    int checks = 0;
    int errors = 0;

    isqrt_seq #(.IN_W(40), .ROUND(1'b0)) u_dut40 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .a_i(a),
        .busy_o(busy40), .valid_o(valid40), .result_o(res40), .rem_o(rem40),
        .exact_o(exact40)
    );

    isqrt_seq #(.IN_W(40), .ROUND(1'b1)) u_dut40r (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .a_i(a),
        .busy_o(busy40r), .valid_o(valid40r), .result_o(res40r), .rem_o(rem40r),
        .exact_o(exact40r)
    );

    isqrt_seq #(.IN_W(16), .ROUND(1'b0)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .start_i(start16), .abort_i(abort16), .a_i(a16),
        .busy_o(busy16), .valid_o(valid16), .result_o(res16), .rem_o(rem16),
        .exact_o(exact16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: floor(sqrt(v)) from floating point, corrected to the exact integer.
    function automatic longint unsigned fsqrt(longint unsigned v);
        longint unsigned y;
        y = longint'($rtoi($sqrt(real'(v))));
        while (y * y > v) y--;
        while ((y + 1) * (y + 1) <= v) y++;
        return y;
    endfunction

    // Nearest integer to sqrt(v): bump when (y + 1/2)^2 < v, clamp to n-bit range.
    function automatic longint unsigned rsqrt(longint unsigned v, int n);
        longint unsigned y;
        longint unsigned lim;
        y   = fsqrt(v);
        lim = (64'd1 << n) - 1;
        if (4 * v > (2 * y + 1) * (2 * y + 1)) y++;
        if (y > lim) y = lim;
        return y;
    endfunction

    // Launch one 40-bit op; optionally re-pulse start with other data at cycle inj.
    task automatic op40(input logic [39:0] val, input int inj, output int vcyc, output int bcnt);
        @(negedge clk);
        a     = val;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vcyc  = 0;
        bcnt  = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == inj) begin
                start = 1'b1;
                a     = val ^ 40'h5A_5A5A_5A5A;
            end
            if (c == inj + 1) start = 1'b0;
            if (busy40) bcnt++;
            if (valid40) begin
                vcyc = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check40(input string tag, input logic [39:0] val, input int vcyc,
                           input int bcnt);
        longint unsigned e;
        longint unsigned rm;
        e  = fsqrt(64'(val));
        rm = 64'(val) - e * e;
        check({tag, " latency"}, 64'(vcyc), 64'd23);
        check({tag, " busy_cycles"}, 64'(bcnt), 64'd22);
        check({tag, " result"}, 64'(res40), e);
        check({tag, " rem"}, 64'(rem40), rm);
        check({tag, " exact"}, 64'(exact40), 64'(rm == 0));
        check({tag, " rnd_valid"}, 64'(valid40r), 64'd1);
        check({tag, " rnd_result"}, 64'(res40r), rsqrt(64'(val), 20));
        check({tag, " rnd_rem"}, 64'(rem40r), rm);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [39:0] dir [7];
        logic [39:0] v;
        logic [39:0] last_a;
        int          vc, bc, vseen, k;
        longint unsigned cur, e16;

        rst = 1'b1; start = 1'b0; abort = 1'b0; a = '0;
        start16 = 1'b0; abort16 = 1'b0; a16 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 64'(busy40), 64'd0);
        check("rst valid", 64'(valid40), 64'd0);
        check("rst result", 64'(res40), 64'd0);
        check("rst rem", 64'(rem40), 64'd0);
        check("rst exact", 64'(exact40), 64'd0);
        check("rst busy16", 64'(busy16), 64'd0);
        rst = 1'b0;

        dir[0] = 40'd1_000_000;
        dir[1] = 40'd0;
        dir[2] = 40'd1;
        dir[3] = 40'hFF_FFFF_FFFF;
        dir[4] = 40'd15;
        dir[5] = 40'd12;
        dir[6] = 40'd20;
        foreach (dir[i]) begin
            op40(dir[i], 0, vc, bc);
            check40($sformatf("dir%0d", i), dir[i], vc, bc);
            if (i == 0) check("1e6 spot", 64'(res40), 64'd1000);
            if (i == 3) check("max sat", 64'(res40r), 64'd1048575);
            if (i == 3) check("max rem", 64'(rem40), 64'd2097150);
        end

        for (int i = 0; i < 20; i++) begin
            v = {$urandom(), $urandom()};
            op40(v, 0, vc, bc);
            check40($sformatf("rnd%0d", i), v, vc, bc);
        end

        // A start pulse mid-operation must neither restart nor queue a new op.
        last_a = 40'd123_456_789;
        op40(last_a, 5, vc, bc);
        check40("start_ignored", last_a, vc, bc);
        vseen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (valid40) vseen++;
        end
        check("no queued op", 64'(vseen), 64'd0);

        // Abort at cycle 10: no completion, previous outputs retained.
        @(negedge clk);
        a = 40'd987_654_321;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort busy drop", 64'(busy40), 64'd0);
        vseen = 0;
        repeat (30) begin
            if (valid40) vseen++;
            @(posedge clk); #1;
        end
        check("abort no valid", 64'(vseen), 64'd0);
        check("abort keeps result", 64'(res40), fsqrt(64'(last_a)));
        check("abort keeps rem", 64'(rem40), 64'(last_a) - fsqrt(64'(last_a)) ** 2);

        // Reset mid-operation clears outputs and abandons the op.
        @(negedge clk);
        a = 40'd55_555_555;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst busy", 64'(busy40), 64'd0);
        check("midrst result", 64'(res40), 64'd0);
        check("midrst rem", 64'(rem40), 64'd0);
        check("midrst exact", 64'(exact40), 64'd0);
        check("midrst rnd result", 64'(res40r), 64'd0);
        vseen = 0;
        repeat (30) begin
            if (valid40) vseen++;
            @(posedge clk); #1;
        end
        check("midrst no valid", 64'(vseen), 64'd0);

        // 16-bit sweep with start held high: each op is accepted straight from DONE.
        @(negedge clk);
        a16     = 16'd0;
        start16 = 1'b1;
        @(posedge clk); #1;
        cur = 0;
        for (int i = 0; i < 3000; i++) begin
            k = 1;
            while (!valid16 && k < 40) begin
                @(posedge clk); #1;
                k++;
            end
            e16 = fsqrt(cur);
            check("b2b spacing", 64'(k), 64'd11);
            check("sw result", 64'(res16), e16);
            check("sw rem", 64'(rem16), cur - e16 * e16);
            check("sw exact", 64'(exact16), 64'((cur - e16 * e16) == 0));
            if (i == 0) a16 = 16'd1;
            else if (i == 1) a16 = 16'hFFFF;
            else a16 = 16'($urandom_range(0, 65535));
            cur = 64'(a16);
            if (i == 2999) start16 = 1'b0;
            @(posedge clk); #1;
        end
        check("sweep idle", 64'(busy16), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
